// File: rtl/lsu.sv
// Load/store unit: one request at a time, word-aligned synchronous reads with
// byte/half extraction, and stores issued as one single-byte write per cycle.
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic [4:0]      resp_rd,
  output logic            resp_err,
  output logic [XLEN-1:0] ram_addr,
  input  logic [XLEN-1:0] ram_rdata,
  output logic            ram_write_en,
  output logic [XLEN-1:0] ram_write_addr,
  output logic [XLEN-1:0] ram_write_data
);

  typedef enum logic [1:0] {IDLE, LOAD_ADDR, LOAD_DATA, STORE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [1:0]      last_q, last_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [4:0]      rd_q, rd_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic [XLEN-1:0] ram_addr_q, ram_addr_d;
  logic [XLEN-1:0] wdata_shift_s;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    if (we) begin
      is_illegal = (f3 > 3'd2);
    end else begin
      is_illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    end
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'd1:    is_misaligned = a[0];
      2'd2:    is_misaligned = (a != 2'd0);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                  input logic [1:0] a,
                                                  input logic [XLEN-1:0] word);
    logic [XLEN-1:0] s;
    s = word >> {a, 3'b000};
    case (f3)
      3'b000:  load_extend = {{(XLEN-8){s[7]}}, s[7:0]};
      3'b001:  load_extend = {{(XLEN-16){s[15]}}, s[15:0]};
      3'b100:  load_extend = {{(XLEN-8){1'b0}}, s[7:0]};
      3'b101:  load_extend = {{(XLEN-16){1'b0}}, s[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  assign wdata_shift_s = wdata_q >> {cnt_q, 3'b000};

  // Next-state, request latching, response and byte-write decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_d         = last_q;
    funct3_d       = funct3_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rd_d           = rd_q;
    resp_valid_d   = 1'b0;
    resp_err_d     = 1'b0;
    resp_rdata_d   = '0;
    ram_addr_d     = ram_addr_q;
    req_ready      = 1'b0;
    ram_write_en   = 1'b0;
    ram_write_addr = '0;
    ram_write_data = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rd_d     = req_rd;
          if (is_illegal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0])) begin
            // Errors answer next cycle without touching the RAM.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we) begin
            state_d = STORE;
            cnt_d   = 2'd0;
            last_d  = (req_funct3[1:0] == 2'd0) ? 2'd0 :
                      (req_funct3[1:0] == 2'd1) ? 2'd1 : 2'd3;
          end else begin
            state_d    = LOAD_ADDR;
            ram_addr_d = {req_addr[XLEN-1:2], 2'b00};
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_ADDR: begin
        state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        resp_rdata_d = load_extend(funct3_q, addr_q[1:0], ram_rdata);
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      STORE: begin
        ram_write_en   = 1'b1;
        ram_write_addr = addr_q + {{(XLEN-2){1'b0}}, cnt_q};
        ram_write_data = {{(XLEN-8){1'b0}}, wdata_shift_s[7:0]};
        if (cnt_q == last_q) begin
          cnt_d        = 2'd0;
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      last_q       <= 2'd0;
      funct3_q     <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 5'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      ram_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      ram_addr_q   <= ram_addr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_rd    = rd_q;
  assign ram_addr   = ram_addr_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: byte-array RAM model, byte-level reference memory, directed
// and random requests, and an asynchronous reset in the middle of a store.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [31:0] ram_addr, ram_rdata;
  logic        ram_write_en;
  logic [31:0] ram_write_addr, ram_write_data;

  logic [7:0]  ram_mem [0:1023];
  logic [7:0]  ref_mem [0:1023];
  int          n_checks = 0;
  int          n_errors = 0;

  lsu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .resp_err(resp_err),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data)
  );

  always #5 clk = ~clk;

  // RAM: byte write and synchronous word read on the same edge
  always @(posedge clk) begin
    if (ram_write_en) ram_mem[ram_write_addr[9:0]] <= ram_write_data[7:0];
    ram_rdata <= {ram_mem[{ram_addr[9:2], 2'd3}], ram_mem[{ram_addr[9:2], 2'd2}],
                  ram_mem[{ram_addr[9:2], 2'd1}], ram_mem[{ram_addr[9:2], 2'd0}]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: what a request should do, from the access rules alone
  task automatic ref_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output bit err,
                         output logic [31:0] rdata, output int nbytes, output int lat);
    int size;
    bit illegal;
    logic [31:0] v;
    size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    rdata   = 32'd0;
    nbytes  = 0;
    err     = 1'b0;
    if (illegal || (addr % size) != 0) begin
      err = 1'b1;
      lat = 1;
    end else if (we) begin
      for (int i = 0; i < size; i++) ref_mem[(addr + i) % 1024] = 8'((wdata >> (8 * i)) & 32'hFF);
      nbytes = size;
      lat    = size + 1;
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[(addr + i) % 1024]) << (8 * i));
      if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
      rdata = v;
      lat   = 3;
    end
  endtask

  // Issues one request at the current negedge and follows it to its response
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        output logic [31:0] got);
    bit e;
    logic [31:0] er;
    int nb, lat, nw;
    bit done;
    ref_req(we, f3, addr, wdata, e, er, nb, lat);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    #1 check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    nw = 0; done = 1'b0; got = 32'd0;
    for (int cyc = 1; cyc <= 8 && !done; cyc++) begin
      @(negedge clk);
      if (!we && !e && cyc == 1) check("ram_addr", ram_addr, {addr[31:2], 2'b00});
      if (ram_write_en) begin
        check("wr_addr", ram_write_addr, addr + 32'(nw));
        check("wr_data", ram_write_data, (wdata >> (8 * nw)) & 32'hFF);
        nw++;
      end
      if (resp_valid) begin
        done = 1'b1;
        got  = resp_rdata;
        check("latency", 32'(cyc), 32'(lat));
        check("resp_err", {31'd0, resp_err}, {31'd0, e});
        check("resp_rdata", resp_rdata, er);
        check("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
      end else begin
        check("req_ready_busy", {31'd0, req_ready}, 32'd0);
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    check("nwrites", 32'(nw), 32'(nb));
  endtask

  initial begin
    logic [31:0] got, a, w;
    logic [2:0]  f;
    bit          we;
    int          nbad;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      ram_mem[i] <= w[7:0];
      ref_mem[i] = w[7:0];
    end
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_wr_en", {31'd0, ram_write_en}, 32'd0);
      check("rst_ram_addr", ram_addr, 32'd0);
    end
    rst = 1'b1;

    do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd2, got);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, got);
    check("lw_100", got, 32'hDEADBEEF);
    do_req(1'b0, 3'b000, 32'h103, 32'h0, 5'd6, got);
    check("lb_103", got, 32'hFFFFFFDE);
    do_req(1'b0, 3'b100, 32'h103, 32'h0, 5'd7, got);
    check("lbu_103", got, 32'h000000DE);
    do_req(1'b0, 3'b001, 32'h102, 32'h0, 5'd8, got);
    check("lh_102", got, 32'hFFFFDEAD);
    do_req(1'b0, 3'b101, 32'h102, 32'h0, 5'd9, got);
    check("lhu_102", got, 32'h0000DEAD);
    do_req(1'b0, 3'b000, 32'h100, 32'h0, 5'd10, got);
    check("lb_100", got, 32'hFFFFFFEF);
    do_req(1'b0, 3'b010, 32'h102, 32'h0, 5'd11, got);
    do_req(1'b0, 3'b011, 32'h100, 32'h0, 5'd12, got);
    do_req(1'b1, 3'b001, 32'h101, 32'h12345678, 5'd13, got);
    do_req(1'b1, 3'b000, 32'h3FF, 32'h000000A5, 5'd14, got);
    do_req(1'b1, 3'b001, 32'h2FE, 32'h0000C3D2, 5'd15, got);
    do_req(1'b0, 3'b001, 32'h2FE, 32'h0, 5'd16, got);
    check("lh_2fe", got, 32'hFFFFC3D2);

    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      f  = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(2'($urandom_range(0, 3)));
      do_req(we, f, a, $urandom, 5'($urandom_range(0, 31)), got);
    end

    // Store cut short by reset after its second byte write
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h200; req_wdata = 32'h11223344; req_rd = 5'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("cut_wr1", {31'd0, ram_write_en}, 32'd1);
    @(negedge clk);
    check("cut_wr2", {31'd0, ram_write_en}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("cut_wr_en", {31'd0, ram_write_en}, 32'd0);
    check("cut_wr_addr", ram_write_addr, 32'd0);
    check("cut_wr_data", ram_write_data, 32'd0);
    check("cut_ready", {31'd0, req_ready}, 32'd1);
    check("cut_resp_err", {31'd0, resp_err}, 32'd0);
    check("cut_resp_rdata", resp_rdata, 32'd0);
    check("cut_resp_rd", {27'd0, resp_rd}, 32'd0);
    check("cut_ram_addr", ram_addr, 32'd0);
    ref_mem[32'h200] = 8'h44;
    ref_mem[32'h201] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("cut_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    rst = 1'b1;
    do_req(1'b0, 3'b010, 32'h200, 32'h0, 5'd4, got);
    check("cut_low_half", {16'd0, got[15:0]}, 32'h00003344);

    nbad = 0;
    for (int i = 0; i < 1024; i++) if (ram_mem[i] !== ref_mem[i]) nbad++;
    check("mem_compare", 32'(nbad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
